// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Signal bundle between the 8N1 serial receiver and the
//                logic around it (baud generator, RX pin, byte consumer).
//                  baud_os_en  - one-clk strobe at OVERSAMPLE x baud rate
//                  rx_in       - asynchronous serial line, idle high
//                  data_out    - last correctly framed byte
//                  data_valid  - one-clk pulse when data_out was just updated
//                  frame_error - one-clk pulse when the stop bit was low
//                  rx_busy     - receiver is inside a frame
//                slave  : the receiver side
//                master : the environment side (driver / consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic       baud_os_en;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       rx_busy;

    modport slave (
        input  baud_os_en,
        input  rx_in,
        output data_out,
        output data_valid,
        output frame_error,
        output rx_busy
    );

    modport master (
        output baud_os_en,
        output rx_in,
        input  data_out,
        input  data_valid,
        input  frame_error,
        input  rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Synchronizes rx_in, validates the start
//                bit at its midpoint, samples 8 data bits (LSB first) and the
//                stop bit at their midpoints using the oversampling enable,
//                and presents the byte with a one-cycle valid strobe. A low
//                stop bit raises a one-cycle frame_error and the receiver
//                then waits for the line to return high.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous, active-low reset
//                rx_if  - uart_rx_if.slave (baud_os_en, rx_in in;
//                         data_out, data_valid, frame_error, rx_busy out)
//  Parameters  : OVERSAMPLE - baud_os_en ticks per bit, even and >= 4
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  rx_if
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] C_HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] C_FULL_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q;
    logic            rx_s_q;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      dout_q, dout_d;
    logic            dv_q, dv_d;
    logic            fe_q, fe_d;

    // Two-flop synchronizer; idle-high reset so reset release never looks
    // like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_if.rx_in;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            // Only half a bit is counted here, so every later sample lands
            // on a bit midpoint.
            S_START: begin
                if (rx_if.baud_os_en) begin
                    if (tick_q == C_HALF_LAST) begin
                        tick_d  = '0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            S_DATA: begin
                if (rx_if.baud_os_en) begin
                    if (tick_q == C_FULL_LAST) begin
                        // Right shift with new bit at MSB: first bit received
                        // ends up in bit 0.
                        shift_d = {rx_s_q, shift_q[7:1]};
                        tick_d  = '0;
                        if (bit_q == 3'd7) begin
                            bit_d   = '0;
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            S_STOP: begin
                if (rx_if.baud_os_en) begin
                    if (tick_q == C_FULL_LAST) begin
                        tick_d = '0;
                        if (rx_s_q) begin
                            dout_d  = shift_q;
                            dv_d    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = S_WAIT_HIGH;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            // A held-low line (break) must not decode as a stream of 0x00.
            S_WAIT_HIGH: begin
                tick_d = '0;
                bit_d  = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign rx_if.data_out    = dout_q;
    assign rx_if.data_valid  = dv_q;
    assign rx_if.frame_error = fe_q;
    assign rx_if.rx_busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8N1 UART link: the receive end of the same frame format that `uart_tx` emits. Samples `rx_in` using an oversampling enable from the shared baud generator, validates the start bit, and shifts in 8 data bits LSB first. Checks the stop bit, then presents the byte on a registered parallel output with a one-cycle valid strobe. It sits between the board RX pin and the command/data consumer logic.

## Interface
- `OVERSAMPLE`, default 16: `baud_os_en` ticks per bit period. Must be an even value ≥ 4.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `baud_os_en` input 1: one-`clk` strobe at `OVERSAMPLE` × baud rate.
- `rx_in` input 1: asynchronous serial line. Idle high.
- `data_out` output 8: last correctly framed byte. Held until the next valid byte.
- `data_valid` output 1: one-`clk` pulse when `data_out` has just been updated.
- `frame_error` output 1: one-`clk` pulse when the stop bit is sampled low.
- `rx_busy` output 1: high in every state except IDLE.

## Operation
- **Input synchronizer.**
  - `rx_in` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
  - All FSM decisions use `rx_s` only.
- **Counters.**
  - `tick_cnt` is `log2(OVERSAMPLE)` bits wide and advances only on `baud_os_en`.
  - `bit_cnt` is 3 bits, 0..7.
  - An 8-bit shift register assembles the byte.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE**
  - `tick_cnt`=0, `bit_cnt`=0.
  - When `rx_s`=0 is seen on any `clk` cycle, go to START.
- **START**
  - On each tick, `tick_cnt`++.
  - When `tick_cnt` reaches `OVERSAMPLE/2-1` on a tick (mid start bit):
    - if `rx_s`=0: clear `tick_cnt` and go to DATA;
    - else (glitch): return to IDLE with no output pulse.
- **DATA**
  - On each tick, `tick_cnt`++.
  - When `tick_cnt`=`OVERSAMPLE-1` on a tick (mid data bit):
    - shift `rx_s` into the MSB of the shift register, shifting right (so the byte ends up LSB-first);
    - clear `tick_cnt`;
    - if `bit_cnt`=7, go to STOP; else `bit_cnt`++.
- **STOP**
  - When `tick_cnt`=`OVERSAMPLE-1` on a tick, sample `rx_s`:
    - if 1: load `data_out` from the shift register, pulse `data_valid`, go to IDLE;
    - if 0: pulse `frame_error`, leave `data_out` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH**
  - Stay until `rx_s`=1, then go to IDLE.
  - This prevents a held-low line (break) from being decoded as repeated 0x00 frames.
- **Other rules.**
  - `baud_os_en` is ignored in IDLE and WAIT_HIGH.
  - Unreachable state encodings go to IDLE.
  - `data_valid` and `frame_error` are never high in the same cycle.

## Timing
- Reset values:
  - `data_out`=0x00; `data_valid`=0; `frame_error`=0; `rx_busy`=0.
  - FSM=IDLE; counters=0; synchronizer=1.
- Reset mid-frame aborts immediately. After release, the block waits for a fresh falling edge.
- `data_valid` and `frame_error` are registered. They assert on the `clk` cycle after the tick that samples the stop bit, and last exactly 1 cycle.
- Latency from the falling edge on `rx_in` to `data_valid` is 2 sync cycles plus (`OVERSAMPLE/2` + 9×`OVERSAMPLE`) ticks plus 1 cycle.
- There is no handshake or backpressure.
  - The consumer must capture `data_out` within one frame time.
  - Overrun overwrites silently.
- Back-to-back frames are supported. A start edge detected on the cycle after the return to IDLE is accepted, so there is no dead time beyond the stop-bit midpoint.
- `rx_busy` is high from the cycle after the falling edge is detected until the return to IDLE.

## Test plan
- **Reset.** Assert `reset`=0 mid-frame after 3 data bits, release, then send 0x3C.
  - Required: no pulse during or after the abort; then one `data_valid` with `data_out`=0x3C.
- **Single byte.** `OVERSAMPLE`=16, send 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1).
  - Required: exactly one `data_valid` pulse; `data_out`=0xA5; `frame_error` never high.
- **Back-to-back.** Send 0x00, 0xFF, 0x55 with no idle gap.
  - Required: three `data_valid` pulses with those values in order.
- **Glitch rejection.** Pull `rx_in` low for 4 ticks, then high.
  - Required: return to IDLE, no pulses, `data_out` unchanged.
- **Framing error.** Send 0x81 with the stop bit low, hold the line low for 40 more ticks, release, then send 0x7E.
  - Required: one `frame_error` pulse; `data_out` stays at its prior value; no spurious frame during the low hold; then `data_valid` with `data_out`=0x7E.
- **Sampling tolerance.** Send 0xC3 with the bit period skewed ±3% relative to the oversample tick.
  - Required: `data_out`=0xC3 with no error.
